// File: rtl/raddr_channel_pkg.sv
// Shared types and constants for the encode-engine read-address channel.
package raddr_channel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PARAM = 2'd1,
    MB    = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int unsigned PARAM_BYTES    = 128;
  localparam int unsigned MB_BYTES       = 384;
  localparam logic [7:0]  MB_ARLEN       = 8'd2;
  localparam logic [2:0]  AXI_SIZE_128B  = 3'b111;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/raddr_channel_credit_cnt.sv
// Outstanding-burst counter: +1 per AR handshake, -1 per rlast handshake,
// never below zero. Also reports whether the next value will be zero.
module raddr_credit_cnt #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       full_o,
  output logic       zero_next_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       dec_ok;

  always_comb begin
    dec_ok = dec_i && (cnt_q != 4'd0);
    cnt_d  = cnt_q;
    if (inc_i && !dec_ok) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!inc_i && dec_ok) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign full_o      = (cnt_q >= 4'(MAX_OUTSTANDING));
  assign zero_next_o = (cnt_d == 4'd0);

endmodule

// File: rtl/raddr_channel.sv
// AXI read-address generator: one param read, then a 3-beat burst per macroblock.
// Optional stall counter output enabled by `define RADDR_PERF_CNT_EN.
module raddr_channel
  import raddr_channel_pkg::*;
#(
  parameter int ID_WIDTH        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_pulse,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [31:0]           mb_count,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rready,
  input  logic                  m_axi_rlast,
  output logic                  busy,
  output logic                  done,
  output state_e                dbg_state,
  output logic [3:0]            dbg_outstanding
`ifdef RADDR_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  // Handshake rule: an AR transfer happens on a clock edge where arvalid and
  // arready are both high; arvalid, araddr and arlen stay stable until then.
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [31:0]           mb_left_q, mb_left_d;
  logic                  done_q, done_d;
  logic                  arvalid;
  logic                  ar_hs, r_done;
  logic                  credit_full, zero_next;
  logic [3:0]            outstanding;

  assign ar_hs  = arvalid & m_axi_arready;
  assign r_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  raddr_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (ar_hs),
    .dec_i      (r_done),
    .cnt_o      (outstanding),
    .full_o     (credit_full),
    .zero_next_o(zero_next)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    mb_left_d = mb_left_q;
    done_d    = 1'b0;
    arvalid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          addr_d    = src_addr;
          len_d     = 8'd0;
          mb_left_d = mb_count;
          state_d   = PARAM;
        end
      end
      PARAM: begin
        arvalid = 1'b1;
        if (ar_hs) begin
          addr_d  = addr_q + ADDR_WIDTH'(PARAM_BYTES);
          len_d   = MB_ARLEN;
          state_d = (mb_left_q == 32'd0) ? DRAIN : MB;
        end
      end
      MB: begin
        // The count only rises on a handshake, so a pending request can never
        // lose its credit; gating directly on the full flag holds arvalid.
        arvalid = !credit_full;
        if (ar_hs) begin
          addr_d    = addr_q + ADDR_WIDTH'(MB_BYTES);
          mb_left_d = mb_left_q - 32'd1;
          if (mb_left_q == 32'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (zero_next) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= 8'd0;
      mb_left_q <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      mb_left_q <= mb_left_d;
      done_q    <= done_d;
    end
  end

`ifdef RADDR_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start_pulse) begin
      stall_d = 32'd0;
    end else if ((state_q == MB) && (!arvalid || !m_axi_arready)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign m_axi_araddr    = addr_q;
  assign m_axi_arlen     = len_q;
  assign m_axi_arsize    = AXI_SIZE_128B;
  assign m_axi_arburst   = AXI_BURST_INCR;
  assign m_axi_arid      = '0;
  assign m_axi_arvalid   = arvalid;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign dbg_state       = state_q;
  assign dbg_outstanding = outstanding;

endmodule

// File: tb/tb_raddr_channel.sv
// Directed bench for raddr_channel: table of complete runs plus hand-written
// sequences for credit limiting, address stalls, same-cycle events and reset.
module tb_raddr_channel;
  import raddr_channel_pkg::*;

  localparam int AW   = 64;
  localparam int IDW  = 2;
  localparam int MAXO = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_pulse;
  logic [AW-1:0] src_addr;
  logic [31:0]   mb_count;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [IDW-1:0] m_axi_arid;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          m_axi_rlast;
  logic          busy;
  logic          done;
  state_e        dbg_state;
  logic [3:0]    dbg_outstanding;
`ifdef RADDR_PERF_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  raddr_channel #(
    .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse),
    .src_addr(src_addr), .mb_count(mb_count),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
    .busy(busy), .done(done),
    .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding)
`ifdef RADDR_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [71:0] exp_q[$];   // {arlen, araddr}

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int          ar_seen = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_r_cyc = 0;
  logic [AW-1:0] last_ar_addr = '0;

  always @(negedge clk) begin
    if (rst_n && m_axi_arvalid && m_axi_arready) begin
      ar_seen++;
      last_ar_addr = m_axi_araddr;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL ar_unexpected: got addr 0x%0h len %0d, expected no request", m_axi_araddr, m_axi_arlen);
      end else begin
        chk("ar_beat", {m_axi_arlen, m_axi_araddr}, exp_q.pop_front());
      end
    end
    if (rst_n && m_axi_rvalid && m_axi_rready && m_axi_rlast) last_r_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- R channel driver ----------------
  // One rlast beat per burst; automatic mode answers every AR, manual mode
  // sends one beat per increment of r_req_total.
  bit r_auto = 1'b0;
  int r_req_total = 0;
  int r_man_sent = 0;
  int r_sent = 0;
  int r_skip = 0;

  initial begin
    m_axi_rvalid = 1'b0;
    m_axi_rready = 1'b0;
    m_axi_rlast  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (r_req_total > r_man_sent) begin
        {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b111;
        r_man_sent++;
        r_sent++;
      end else if (r_auto && (ar_seen - r_skip > r_sent)) begin
        {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b111;
        r_sent++;
      end else begin
        {m_axi_rvalid, m_axi_rready, m_axi_rlast} = 3'b000;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [AW-1:0] a, input logic [31:0] n);
    @(posedge clk); #1;
    start_pulse = 1'b1;
    src_addr    = a;
    mb_count    = n;
    @(posedge clk); #1;
    start_pulse = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input int n);
    exp_q.push_back({8'd0, a});
    for (int i = 0; i < n; i++)
      exp_q.push_back({8'd2, a + 64'd128 + 64'(i) * 64'd384});
  endtask

  task automatic wait_ar(input int target, input string name);
    int k = 0;
    while (ar_seen < target && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 72'(ar_seen >= target), 72'd1);
  endtask

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 72'(done_cnt != d0), 72'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] src;
    logic [31:0]   mbc;
    logic [AW-1:0] last_addr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int d0, a0;
    rst_n         = 1'b0;
    start_pulse   = 1'b0;
    src_addr      = '0;
    mb_count      = '0;
    m_axi_arready = 1'b1;

    tbl[0] = '{src: 64'h1000,                mbc: 32'd2, last_addr: 64'h1200};
    tbl[1] = '{src: 64'h4000,                mbc: 32'd0, last_addr: 64'h4000};
    tbl[2] = '{src: 64'h2000,                mbc: 32'd4, last_addr: 64'h2500};
    tbl[3] = '{src: 64'hFFFF_FFFF_FFFF_FF80, mbc: 32'd1, last_addr: 64'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {m_axi_arvalid, busy, done, m_axi_arlen, m_axi_araddr}, 72'd0);
    chk("rst_const", {m_axi_arid, m_axi_arburst, m_axi_arsize}, {2'b00, 2'b01, 3'b111});
    chk("rst_state", {dbg_outstanding, 2'(dbg_state)}, {4'd0, 2'(IDLE)});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Complete runs with arready high and prompt R data
    r_auto = 1'b1;
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      a0 = ar_seen;
      push_exp(tbl[v].src, int'(tbl[v].mbc));
      pulse_start(tbl[v].src, tbl[v].mbc);
      @(negedge clk);
      chk("first_ar", {busy, m_axi_arvalid, m_axi_arlen, m_axi_araddr}, {2'b11, 8'd0, tbl[v].src});
      wait_done(d0, "run_done");
      chk("run_ar_count", 72'(ar_seen - a0), 72'(tbl[v].mbc + 1));
      chk("run_last_addr", last_ar_addr, tbl[v].last_addr);
      chk("done_latency", 72'(done_cyc - last_r_cyc), 72'd1);
      repeat (5) @(negedge clk);
      chk("done_once_idle", {busy, 32'(done_cnt - d0)}, {1'b0, 32'd1});
      chk("exp_empty", 72'(exp_q.size()), 72'd0);
    end

    // Credit limit: data withheld, only MAXO requests go out
    r_auto = 1'b0;
    d0 = done_cnt;
    a0 = ar_seen;
    push_exp(64'h6000, 5);
    pulse_start(64'h6000, 32'd5);
    repeat (20) @(negedge clk);
    chk("credit_stop", {m_axi_arvalid, dbg_outstanding, 32'(ar_seen - a0)}, {1'b0, 4'd3, 32'd3});
    pulse_start(64'h9000, 32'd9);   // ignored while busy
    repeat (4) @(negedge clk);
    chk("start_busy_ignored", {m_axi_arvalid, 32'(ar_seen - a0)}, {1'b0, 32'd3});
    r_req_total++;
    repeat (6) @(negedge clk);
    chk("credit_release1", {m_axi_arvalid, 32'(ar_seen - a0)}, {1'b0, 32'd4});
    r_req_total++;
    repeat (6) @(negedge clk);
    chk("credit_release2", {m_axi_arvalid, 32'(ar_seen - a0)}, {1'b0, 32'd5});
    r_auto = 1'b1;
    wait_done(d0, "credit_done");
    chk("credit_total", {72'(ar_seen - a0)}, 72'd6);
    repeat (3) @(negedge clk);

    // arready held low 10 cycles during MB
    d0 = done_cnt;
    a0 = ar_seen;
    push_exp(64'h3000, 2);
    pulse_start(64'h3000, 32'd2);
    wait_ar(a0 + 1, "stall_param");
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {m_axi_arvalid, m_axi_arlen, m_axi_araddr}, {1'b1, 8'd2, 64'h3080});
    end
    @(posedge clk); #1;
    m_axi_arready = 1'b1;
    wait_done(d0, "stall_done");
    chk("stall_total", 72'(ar_seen - a0), 72'd3);
    repeat (3) @(negedge clk);

    // Same-cycle ar_hs and r_done at outstanding=2
    r_auto = 1'b0;
    a0 = ar_seen;
    push_exp(64'h5000, 5);
    pulse_start(64'h5000, 32'd5);
    wait_ar(a0 + 2, "same_setup");
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    @(negedge clk);
    chk("same_pre", {m_axi_arvalid, dbg_outstanding}, {1'b1, 4'd2});
    @(posedge clk); #1;
    m_axi_arready = 1'b1;
    r_req_total++;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    @(negedge clk);
    chk("same_post", {dbg_outstanding, 32'(ar_seen - a0)}, {4'd2, 32'd3});

    // Reset mid-MB, then a fresh run
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {m_axi_arvalid, busy, done, m_axi_arlen, m_axi_araddr}, 72'd0);
    chk("midrst_state", {dbg_outstanding, 2'(dbg_state)}, {4'd0, 2'(IDLE)});
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_axi_arready = 1'b1;
    exp_q.delete();
    r_skip = ar_seen - r_sent;
    r_auto = 1'b1;
    d0 = done_cnt;
    a0 = ar_seen;
    push_exp(64'h8000, 1);
    pulse_start(64'h8000, 32'd1);
    wait_done(d0, "fresh_done");
    chk("fresh_total", {72'(ar_seen - a0)}, 72'd2);
    chk("fresh_last", last_ar_addr, 64'h8080);
    repeat (3) @(negedge clk);
    chk("fresh_idle", {busy, 32'(exp_q.size())}, 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
